sram_like_mem_slave: RTL and testbench
======================================

// Module: sram_like_mem_slave
// PURPOSE
//   Responder end of the sram-like data interface (req/wr/size/addr/wstrb/wdata -> addr_ok/data_ok/rdata).
//   Backs the interface with an on-chip word RAM, supports pipelined outstanding requests and returns responses in order after a fixed latency.
//   Used as the data-side memory model/slave behind the EXE/MEM stages in standalone CPU simulation and FPGA bring-up.
// PARAMETERS
//   MEM_AW     10  word-address width of RAM (2**MEM_AW 32-bit words)
//   LATENCY    2   cycles from accept edge to data_ok; legal range 1..15
//   MAX_OUTST  4   max accepted-but-unanswered requests; power of 2, >=2
// PORTS
//   clk      in   1   clock
//   reset    in   1   synchronous, active-high reset
//   req      in   1   request valid from master
//   wr       in   1   1=write, 0=read
//   size     in   2   0=byte,1=half,2=word; recorded only, not used for RAM access
//   addr     in   32  byte address; word index = addr[MEM_AW+1:2]
//   wstrb    in   4   byte enables for writes
//   wdata    in   32  write data, already lane-aligned by master
//   addr_ok  out  1   request accepted this cycle when req&&addr_ok
//   data_ok  out  1   one-cycle response pulse, one per accepted request
//   rdata    out  32  read word, valid only with data_ok of a read
// BEHAVIOUR
//   - Reset: addr_ok=0 while reset high, data_ok=0, rdata=0; outstanding count, FIFO pointers, age counters cleared. RAM contents not reset.
//   - Accept: addr_ok = (count < MAX_OUTST) [& stall gate, see CONFIGURATION]; combinational from registered state only, never from req.
//     No full-bypass: if count==MAX_OUTST, addr_ok=0 even when a retire happens in the same cycle.
//   - Writes commit to RAM at the accept edge: byte i written iff wstrb[i]; wr=1 with wstrb=0 is a legal no-op that still gets data_ok.
//   - Reads sample RAM at the accept edge, after any write accepted earlier; the read word is stored in the response FIFO entry.
//     A read therefore always sees all previously accepted writes.
//   - Address bits above MEM_AW+1 and addr[1:0] are ignored; out-of-range addresses alias, no error is raised.
//   - Response FIFO: MAX_OUTST entries {is_read, rdata, age}; push on accept, pop on data_ok; pointers wrap modulo MAX_OUTST.
//   - Timing: request accepted at edge T gives data_ok=1 in the cycle after edge T+LATENCY-1 (LATENCY=1 -> the cycle right after accept).
//     Strictly in order, at most one data_ok per cycle; head pops only when its age reaches LATENCY.
//   - data_ok and rdata are registered. rdata=stored word for a read response; 0 for write responses and idle cycles.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Reset mid-operation: all outstanding entries dropped, no data_ok follows; master must also discard its pending state.
//   - size is captured for debug only; no alignment or size checking in this block.
// CONFIGURATION
//   SRAM_SLAVE_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
//     addr_ok is additionally forced to 0 whenever lfsr[0]==1. Response latency is unchanged.
//   Not defined: no LFSR; addr_ok depends only on count (and reset).
// TESTING
//   1. Hold reset 3 cycles with req=1 -> addr_ok=0, data_ok=0 throughout; first cycle after release addr_ok=1.
//   2. Write 0x10 wdata=0x11223344 wstrb=4'hF, then read 0x10 -> read data_ok exactly LATENCY cycles after its accept, rdata=0x11223344.
//   3. Then write 0x10 wdata=0xAABBCCDD wstrb=4'b0010 and read 0x10 -> rdata=0x1122CC44; the write's data_ok carries rdata=0.
//   4. LATENCY=8, MAX_OUTST=4, req held high for reads of 0x0,0x4,0x8,0xC,0x10 -> 4 accepts back-to-back, then addr_ok=0 until the cycle after the first data_ok;
//      5th accepted then; 5 data_ok in address order.
//   5. Accept 3 reads (LATENCY=4), assert reset 1 cycle before the first response -> no data_ok ever appears; count=0, addr_ok=1 after release.
//   6. SRAM_SLAVE_STALL_EN, req held 1000 cycles of mixed rd/wr -> accepts <1000, addr_ok=0 on every cycle with lfsr[0]=1, responses in order, read data matches a scoreboard.

Source files
------------

// File: rtl/sram_like_mem_slave_if.sv
// sram-like data-side bus: request channel driven by the master,
// accept/response channel driven by the memory slave.
interface sram_like_mem_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: on-chip word RAM behind the sram-like data bus.
// Writes commit and reads sample the RAM at the accept edge; the result is
// parked in an in-order response FIFO and returned LATENCY cycles after the
// accept cycle as a registered one-cycle data_ok pulse.
// Optional feature macro: SRAM_SLAVE_STALL_EN (LFSR-driven random stalls on addr_ok).
module sram_like_mem_slave #(
  parameter int MEM_AW    = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_like_mem_slave_if.slave bus
);
  localparam int         PW      = $clog2(MAX_OUTST);
  localparam int         CW      = PW + 1;
  localparam logic [3:0] AGE_DUE = 4'(LATENCY - 1);
  localparam bit         LAT1    = (LATENCY == 1);

  // age = accept edges elapsed since push; entry is due once it reaches LATENCY-1,
  // so its data_ok lands LATENCY cycles after the accept cycle
  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
    logic [3:0]  age;
  } resp_t;

  logic [31:0]       mem [2**MEM_AW];
  resp_t             fifo [MAX_OUTST];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;     // accepted and data_ok cycle not yet finished
  logic [CW-1:0]     fifo_cnt;  // entries still waiting for their data_ok
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic [1:0]        size_q;
  logic              stall;
  logic              accept, bypass, push, pop;
  logic [MEM_AW-1:0] widx;
  logic [31:0]       rd_word;

`ifdef SRAM_SLAVE_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running; bit 0 throttles acceptance
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // No full-bypass: a retire in the same cycle does not reopen a full slave
  assign bus.addr_ok = !reset && (count < CW'(MAX_OUTST)) && !stall;
  assign accept      = bus.req && bus.addr_ok;
  assign widx        = bus.addr[MEM_AW+1:2];
  assign rd_word     = mem[widx];

  // LATENCY==1 responds at the accept edge itself, so the FIFO is skipped
  assign bypass = LAT1 && accept;
  assign push   = accept && !bypass;
  assign pop    = (fifo_cnt != '0) && (fifo[rd_ptr].age >= AGE_DUE);

  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

  // RAM write port: enabled byte lanes commit at the accept edge
  always_ff @(posedge clk) begin
    if (accept && bus.wr)
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
  end

  // Response FIFO storage; ages saturate so an idle slot never wraps to "due"
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTST; i++) fifo[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTST; i++)
        if (fifo[i].age != 4'hF) fifo[i].age <= fifo[i].age + 4'd1;
      if (push) fifo[wr_ptr] <= '{is_read: !bus.wr, rdata: rd_word, age: 4'd1};
    end
  end

  // Pointers, occupancy counters and the registered response pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      count     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      size_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
      count     <= count + CW'(accept) - CW'(data_ok_q);
      data_ok_q <= pop || bypass;
      if (pop)
        rdata_q <= fifo[rd_ptr].is_read ? fifo[rd_ptr].rdata : '0;
      else if (bypass && !bus.wr)
        rdata_q <= rd_word;
      else
        rdata_q <= '0;
      if (accept) size_q <= bus.size;
    end
  end

  // size is kept for debug visibility only; address bits outside the word index alias
  logic unused_bits;
  assign unused_bits = ^{size_q, bus.addr[31:MEM_AW+2], bus.addr[1:0]};
endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: reset, a directed vector table and a randomized
// run on a LATENCY=2 instance checked against a queue/array reference model,
// plus fixed sequences on LATENCY=1, 4 and 8 instances.
module tb_sram_like_mem_slave;
  localparam int AW   = 10;
  localparam int LAT  = 2;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m = 1'b1, rst1 = 1'b1, rst4 = 1'b1, rst8 = 1'b1;

  sram_like_mem_slave_if bm();
  sram_like_mem_slave_if b1();
  sram_like_mem_slave_if b4();
  sram_like_mem_slave_if b8();

  sram_like_mem_slave #(.MEM_AW(AW), .LATENCY(LAT), .MAX_OUTST(MAXO)) dut  (.clk(clk), .reset(rst_m), .bus(bm));
  sram_like_mem_slave #(.MEM_AW(AW), .LATENCY(1),   .MAX_OUTST(2))    dut1 (.clk(clk), .reset(rst1),  .bus(b1));
  sram_like_mem_slave #(.MEM_AW(AW), .LATENCY(4),   .MAX_OUTST(4))    dut4 (.clk(clk), .reset(rst4),  .bus(b4));
  sram_like_mem_slave #(.MEM_AW(AW), .LATENCY(8),   .MAX_OUTST(4))    dut8 (.clk(clk), .reset(rst8),  .bus(b8));

  // reference model: word array + queue of promised responses with due cycle
  typedef struct { bit rd; logic [31:0] data; int due; } exp_t;
  exp_t        q[$];
  logic [31:0] mm [1<<AW];
  int          cyc = 0, checks = 0, errors = 0;
  bit          acc_flag, got_dok;
  int          acc_cyc, dok_cyc;
  logic [31:0] last_rdata;
`ifdef SRAM_SLAVE_STALL_EN
  logic [15:0] tl = 16'hACE1;
`endif

  typedef struct { bit wr; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // one cycle on the main instance: check against model, then advance model
  task automatic step();
    bit   eao;
    exp_t e;
    int   idx;
    @(negedge clk);
    eao = !rst_m && (q.size() < MAXO);
`ifdef SRAM_SLAVE_STALL_EN
    eao = eao && !tl[0];
`endif
    chk("addr_ok", bm.addr_ok, 32'(eao));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("data_ok", bm.data_ok, 1);
      chk("rdata", bm.rdata, q[0].rd ? q[0].data : 32'h0);
      void'(q.pop_front());
    end else begin
      chk("data_ok idle", bm.data_ok, 0);
      chk("rdata idle", bm.rdata, 0);
    end
    if (bm.data_ok === 1'b1) begin got_dok = 1; dok_cyc = cyc; last_rdata = bm.rdata; end
    if (rst_m) q.delete();
    else if (bm.req && bm.addr_ok) begin
      idx = int'((bm.addr >> 2) & 32'((1 << AW) - 1));
      e.rd = !bm.wr; e.due = cyc + LAT; e.data = 32'h0;
      if (bm.wr) begin
        for (int b = 0; b < 4; b++) if (bm.wstrb[b]) mm[idx][8*b +: 8] = bm.wdata[8*b +: 8];
      end else e.data = mm[idx];
      q.push_back(e);
      acc_flag = 1; acc_cyc = cyc;
    end
`ifdef SRAM_SLAVE_STALL_EN
    tl = rst_m ? 16'hACE1 : {tl[0] ^ tl[2] ^ tl[3] ^ tl[5], tl[15:1]};
`endif
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic burst8(input bit w);
    int a[5], d[5];
    logic [31:0] rv[5];
    int na = 0, nd = 0, t = 0;
    for (int i = 0; i < 5; i++) begin a[i] = -100; d[i] = -200; rv[i] = 32'hX; end
    while (nd < 5 && t < 80) begin
      b8.req = (na < 5); b8.wr = w; b8.addr = 32'(na * 4); b8.wstrb = 4'hF;
      b8.wdata = 32'hA000_0000 + 32'(na); b8.size = 2'd2;
      @(negedge clk);
      if (b8.data_ok) begin if (nd < 5) begin d[nd] = t; rv[nd] = b8.rdata; end nd++; end
      if (b8.req && b8.addr_ok) begin a[na] = t; na++; end
      @(posedge clk); #1; t++;
    end
    b8.req = 0;
    chk("b8 responses", 32'(nd), 5);
    for (int i = 1; i < 4; i++) chk("b8 back-to-back", 32'(a[i] - a[0]), 32'(i));
    chk("b8 5th accept after 1st data_ok", 32'(a[4] - d[0]), 1);
    for (int i = 0; i < 5; i++) begin
      chk("b8 latency", 32'(d[i] - a[i]), 8);
      chk("b8 rdata", rv[i], w ? 32'h0 : 32'hA000_0000 + 32'(i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] ra;
    tv[0]  = '{1'b1, 32'h10,       4'hF, 32'h11223344, 32'h0};
    tv[1]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'h11223344};
    tv[2]  = '{1'b1, 32'h10,       4'h2, 32'hAABBCCDD, 32'h0};
    tv[3]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'h1122CC44};
    tv[4]  = '{1'b1, 32'h20,       4'hF, 32'hDEADBEEF, 32'h0};
    tv[5]  = '{1'b1, 32'h20,       4'h0, 32'hFFFFFFFF, 32'h0};
    tv[6]  = '{1'b0, 32'h20,       4'h0, 32'h0,        32'hDEADBEEF};
    tv[7]  = '{1'b1, 32'h1010,     4'h8, 32'h55667788, 32'h0};
    tv[8]  = '{1'b0, 32'h13,       4'h0, 32'h0,        32'h5522CC44};
    tv[9]  = '{1'b1, 32'hFFC,      4'hF, 32'h01020304, 32'h0};
    tv[10] = '{1'b0, 32'hFFFFFFFE, 4'h0, 32'h0,        32'h01020304};

    {b1.req, b1.wr, b1.size, b1.addr, b1.wstrb, b1.wdata} = '0;
    {b4.req, b4.wr, b4.size, b4.addr, b4.wstrb, b4.wdata} = '0;
    {b8.req, b8.wr, b8.size, b8.addr, b8.wstrb, b8.wdata} = '0;
    bm.req = 1; bm.wr = 0; bm.size = 2; bm.addr = 0; bm.wstrb = 0; bm.wdata = 0;

    // reset held 3 cycles with req high, then released
    @(posedge clk); #1;
    repeat (3) step();
    rst_m = 0; bm.req = 0;
    step();

    // directed vectors, one transaction at a time
    for (int i = 0; i < 11; i++) begin
      bm.req = 1; bm.wr = tv[i].wr; bm.addr = tv[i].addr; bm.wstrb = tv[i].strb;
      bm.wdata = tv[i].wdata; bm.size = 2;
      acc_flag = 0; n = 0;
      while (!acc_flag && n < 30) begin step(); n++; end
      bm.req = 0;
      chk("vec accepted", 32'(acc_flag), 1);
      got_dok = 0; n = 0;
      while (!got_dok && n < 30) begin step(); n++; end
      chk("vec data_ok seen", 32'(got_dok), 1);
      chk("vec rdata", last_rdata, tv[i].exp);
      chk("vec latency", 32'(dok_cyc - acc_cyc), LAT);
    end

    // preload the random-test window so every read has defined data
    n = 0;
    for (int k = 0; k < 200 && n < 16; k++) begin
      bm.req = 1; bm.wr = 1; bm.wstrb = 4'hF; bm.wdata = $urandom;
      bm.addr = 32'((16'h40 + n) << 2);
      acc_flag = 0; step();
      if (acc_flag) n++;
    end
    chk("preload done", 32'(n), 16);

    // random mixed traffic with aliasing high bits and a mid-run reset
    for (int i = 0; i < 800; i++) begin
      rst_m    = (i == 400 || i == 401);
      bm.req   = ($urandom_range(9) < 7);
      bm.wr    = $urandom_range(1);
      bm.size  = 2'($urandom_range(2));
      ra       = $urandom;
      ra[11:2] = 10'(16'h40 + $urandom_range(15));
      bm.addr  = ra;
      bm.wstrb = 4'($urandom);
      bm.wdata = $urandom;
      step();
    end
    rst_m = 0; bm.req = 0;
    repeat (20) step();
    chk("model queue drained", 32'(q.size()), 0);

`ifndef SRAM_SLAVE_STALL_EN
    // LATENCY=1: write then read back-to-back, responses the cycle after accept
    rst1 = 0;
    for (int k = 0; k < 4; k++) begin
      b1.req = (k < 2); b1.wr = (k == 0); b1.addr = 32'h8; b1.wstrb = 4'hF;
      b1.wdata = 32'hCAFEF00D; b1.size = 2;
      @(negedge clk);
      chk("l1 addr_ok", b1.addr_ok, 1);
      chk("l1 data_ok", b1.data_ok, (k == 1 || k == 2) ? 1 : 0);
      chk("l1 rdata", b1.rdata, (k == 2) ? 32'hCAFEF00D : 32'h0);
      @(posedge clk); #1;
    end
    b1.req = 0;

    // LATENCY=8, MAX_OUTST=4: writes fill the words, then reads return them in order
    rst8 = 0;
    burst8(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    burst8(1'b0);

    // LATENCY=4: reset one cycle before the first response drops everything
    rst4 = 0;
    n = 0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      b4.req = 1; b4.wr = 0; b4.addr = 32'(n * 4); b4.size = 2;
      @(negedge clk);
      if (b4.req && b4.addr_ok) n++;
      @(posedge clk); #1;
    end
    b4.req = 0; rst4 = 1;
    chk("r4 accepts", 32'(n), 3);
    @(negedge clk);
    chk("r4 data_ok in reset", b4.data_ok, 0);
    @(posedge clk); #1;
    rst4 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("r4 no data_ok", b4.data_ok, 0);
      chk("r4 addr_ok", b4.addr_ok, 1);
      @(posedge clk); #1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
